// File: rtl/cv32e40p_x_result_buf.sv
// Result buffer between the X-interface coprocessor result channel and the
// core register file. Results are queued in a small FIFO and drained one per
// cycle into the dedicated X write port whenever the core is not using it.
// Buffered destination registers are exposed so the offload dispatcher can
// stall dependent instructions, and each register write is mirrored by a
// scoreboard-clear pulse.
module cv32e40p_x_result_buf #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned X_ID_WIDTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         x_result_valid_i,
    output logic                         x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]        x_result_id_i,
    input  logic [X_RFW_WIDTH-1:0]       x_result_data_i,
    input  logic [4:0]                   x_result_rd_i,
    input  logic                         x_result_we_i,
    input  logic                         wb_port_busy_i,
    input  logic [14:0]                  x_rs_addr_i,
    output logic                         regfile_x_we_o,
    output logic [4:0]                   regfile_x_waddr_o,
    output logic [X_RFW_WIDTH-1:0]       regfile_x_wdata_o,
    output logic                         sb_clr_valid_o,
    output logic [4:0]                   sb_clr_rd_o,
    output logic [X_ID_WIDTH-1:0]        sb_clr_id_o,
    output logic [2:0]                   pending_match_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]             rd_q   [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic                   vld_q  [DEPTH];

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full_o           = (count_q == CNT_W'(DEPTH));
    assign empty_o          = (count_q == '0);
    assign count_o          = count_q;
    // Ready depends on registered occupancy only, never on a same-cycle pop.
    assign x_result_ready_o = ~full_o;

    // Results without a register write (or targeting x0) are accepted and dropped.
    assign push = x_result_valid_i & x_result_ready_o & x_result_we_i & (x_result_rd_i != 5'd0);
    assign pop  = regfile_x_we_o;

    assign regfile_x_we_o    = ~empty_o & ~wb_port_busy_i;
    assign regfile_x_waddr_o = rd_q[rptr_q];
    assign regfile_x_wdata_o = data_q[rptr_q];
    assign sb_clr_valid_o    = regfile_x_we_o;
    assign sb_clr_rd_o       = rd_q[rptr_q];
    assign sb_clr_id_o       = id_q[rptr_q];

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                vld_q[e] <= 1'b0;
            end
        end else begin
            if (pop) begin
                rptr_q        <= ptr_inc(rptr_q);
                vld_q[rptr_q] <= 1'b0;
            end
            if (push) begin
                wptr_q        <= ptr_inc(wptr_q);
                vld_q[wptr_q] <= 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry payload storage; not reset, only meaningful while the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_q[wptr_q]   <= x_result_rd_i;
            id_q[wptr_q]   <= x_result_id_i;
            data_q[wptr_q] <= x_result_data_i;
        end
    end

    // Compare each source register of the ID-stage instruction against every buffered rd.
    always_comb begin
        pending_match_o = '0;
        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (vld_q[e] && (x_rs_addr_i[i*5 +: 5] != 5'd0) &&
                    (rd_q[e] == x_rs_addr_i[i*5 +: 5])) begin
                    pending_match_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// Self-checking bench for cv32e40p_x_result_buf (DEPTH=2).
module tb_cv32e40p_x_result_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_valid;
    logic        x_ready;
    logic [3:0]  x_id;
    logic [31:0] x_data;
    logic [4:0]  x_rd;
    logic        x_we;
    logic        busy;
    logic [14:0] x_rs;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_vld;
    logic [4:0]  sb_rd;
    logic [3:0]  sb_id;
    logic [2:0]  pm;
    logic [1:0]  cnt;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  id;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];

    cv32e40p_x_result_buf #(.DEPTH(DEPTH), .X_RFW_WIDTH(32), .X_ID_WIDTH(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .x_result_valid_i (x_valid),
        .x_result_ready_o (x_ready),
        .x_result_id_i    (x_id),
        .x_result_data_i  (x_data),
        .x_result_rd_i    (x_rd),
        .x_result_we_i    (x_we),
        .wb_port_busy_i   (busy),
        .x_rs_addr_i      (x_rs),
        .regfile_x_we_o   (rf_we),
        .regfile_x_waddr_o(rf_waddr),
        .regfile_x_wdata_o(rf_wdata),
        .sb_clr_valid_o   (sb_vld),
        .sb_clr_rd_o      (sb_rd),
        .sb_clr_id_o      (sb_id),
        .pending_match_o  (pm),
        .count_o          (cnt),
        .empty_o          (empty),
        .full_o           (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated once per clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk_en = 1'b1;
        end else begin
            bit acc;
            bit drain;
            acc   = (q.size() < DEPTH) && x_valid;
            drain = (q.size() > 0) && !busy;
            if (drain) void'(q.pop_front());
            if (acc && x_we && (x_rd != 5'd0)) begin
                ent_t e;
                e.rd = x_rd; e.id = x_id; e.data = x_data;
                q.push_back(e);
            end
        end
    end

    // Compare all outputs against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic       exp_we;
            logic [2:0] exp_pm;
            exp_we = (q.size() > 0) && !busy;
            chk("m_count", cnt, q.size());
            chk("m_empty", empty, q.size() == 0);
            chk("m_full", full, q.size() == DEPTH);
            chk("m_ready", x_ready, q.size() < DEPTH);
            chk("m_we", rf_we, exp_we);
            chk("m_sbvld", sb_vld, exp_we);
            if (exp_we) begin
                chk("m_waddr", rf_waddr, q[0].rd);
                chk("m_wdata", rf_wdata, q[0].data);
                chk("m_sbrd", sb_rd, q[0].rd);
                chk("m_sbid", sb_id, q[0].id);
            end
            exp_pm = '0;
            for (int i = 0; i < 3; i++) begin
                logic [4:0] rs;
                rs = 5'((x_rs >> (5 * i)) & 15'h1f);
                foreach (q[k]) if (rs != 0 && q[k].rd == rs) exp_pm[i] = 1'b1;
            end
            chk("m_pm", pm, exp_pm);
        end
    end

    task automatic push(input logic [4:0] rd, input logic [31:0] data,
                        input logic [3:0] id, input logic we);
        x_valid = 1'b1; x_rd = rd; x_data = data; x_id = id; x_we = we;
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int wr_seen;
        rst_n = 1'b0; x_valid = 1'b0; x_id = '0; x_data = '0; x_rd = '0;
        x_we = 1'b0; busy = 1'b0; x_rs = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", x_ready, 1); chk("rst_we", rf_we, 0);
        chk("rst_sbvld", sb_vld, 0); chk("rst_pm", pm, 0);
        chk("rst_count", cnt, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        tick(); rst_n = 1'b1;

        // Single result, port free: written the cycle after acceptance.
        push(5'd5, 32'hDEADBEEF, 4'd3, 1'b1);
        @(negedge clk);
        chk("t1_we", rf_we, 1); chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t1_sbrd", sb_rd, 5); chk("t1_sbid", sb_id, 3);
        @(negedge clk);
        chk("t1_empty", empty, 1);

        // Fill while port busy, then drain in order.
        tick(); busy = 1'b1;
        push(5'd1, 32'h11, 4'd1, 1'b1);
        push(5'd2, 32'h22, 4'd2, 1'b1);
        @(negedge clk);
        chk("t2_full", full, 1); chk("t2_ready", x_ready, 0);
        tick(); busy = 1'b0;
        @(negedge clk);
        chk("t2_w1", rf_waddr, 1); chk("t2_we1", rf_we, 1); chk("t2_rdy_full", x_ready, 0);
        tick();
        @(negedge clk);
        chk("t2_w2", rf_waddr, 2); chk("t2_we2", rf_we, 1); chk("t2_rdy_after", x_ready, 1);
        @(negedge clk);
        chk("t2_empty", empty, 1);

        // Dropped results: we=0 and rd=0.
        tick();
        x_valid = 1'b1; x_rd = 5'd9; x_we = 1'b0; x_data = 32'h99;
        @(negedge clk); chk("t3_ready_a", x_ready, 1);
        tick();
        x_rd = 5'd0; x_we = 1'b1;
        @(negedge clk); chk("t3_ready_b", x_ready, 1);
        tick(); x_valid = 1'b0;
        @(negedge clk);
        chk("t3_count", cnt, 0); chk("t3_we", rf_we, 0); chk("t3_sbvld", sb_vld, 0);

        // Pending match: rs[0]=7, rs[1]=0, rs[2]=3.
        tick(); busy = 1'b1; x_rs = {5'd3, 5'd0, 5'd7};
        push(5'd7, 32'h77, 4'd7, 1'b1);
        @(negedge clk); chk("t4_pm_busy", pm, 3'b001);
        tick(); busy = 1'b0;
        @(negedge clk); chk("t4_pm_head", pm, 3'b001); chk("t4_we", rf_we, 1);
        tick();
        @(negedge clk); chk("t4_pm_after", pm, 3'b000);
        x_rs = '0;

        // Steady-state stream: one push and one pop per cycle.
        tick();
        for (int k = 0; k < 10; k++) begin
            x_valid = 1'b1; x_we = 1'b1; x_rd = 5'(k + 1);
            x_data = 32'hA000 + 32'(k); x_id = 4'(k);
            tick();
            @(negedge clk);
            chk("t5_count", cnt, 1);
            chk("t5_waddr", rf_waddr, 5'(k + 1));
        end
        x_valid = 1'b0;
        tick(); tick();

        // Reset while full discards both entries.
        busy = 1'b1;
        push(5'd11, 32'hB1, 4'd1, 1'b1);
        push(5'd12, 32'hB2, 4'd2, 1'b1);
        @(negedge clk); chk("t6_full", full, 1);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1; busy = 1'b0;
        @(negedge clk); chk("t6_empty", empty, 1);
        wr_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (rf_we) wr_seen++;
            @(negedge clk);
        end
        chk("t6_no_writes", wr_seen, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
